// File: rtl/core_pkg.sv
// Core-wide widths and the writeback request record shared by the
// execute/memory writeback sources and the register-file write port.
package core_pkg;

  localparam int XLEN       = 64;
  localparam int REG_AW     = 5;
  localparam int NUM_WB_SRC = 3;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from ptr, wrapping.
// Handshake: a request i is consumed when req_i[i] && grant_o[i]; grant may depend on req_i.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               hold_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               grant_valid_o,
  output logic [IW-1:0]      grant_idx_o
);

  localparam int CW = IW + 1;

  logic [IW-1:0] ptr_q;
  logic [CW-1:0] cand;
  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + CW'(i);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!found && req_i[cand[IW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
    // No grants while frozen or while held in reset.
    if (hold_i || !reset_n) found = 1'b0;
  end

  assign grant_valid_o = found;
  assign grant_idx_o   = idx;
  assign grant_o       = found ? (NUM_REQ'(1) << idx) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (found) begin
      ptr_q <= (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port among NUM_SRC writeback sources:
// round-robin grant, then a one-entry registered output stage.
module wb_port_arbiter
  import core_pkg::*;
#(
  parameter int NUM_SRC = core_pkg::NUM_WB_SRC,
  parameter int XLEN    = core_pkg::XLEN,
  parameter int REG_AW  = core_pkg::REG_AW,
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_SRC-1:0]        src_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0] src_rd_addr_i,
  input  logic [NUM_SRC*XLEN-1:0]   src_data_i,
  output logic [NUM_SRC-1:0]        src_ready_o,
  input  logic                      hold_i,
  output logic                      rf_wr_en_o,
  output logic [REG_AW-1:0]         rf_rd_addr_o,
  output logic [XLEN-1:0]           rf_wr_data_o,
  output logic [SW-1:0]             grant_src_o
);

  logic              grant_valid;
  logic [SW-1:0]     grant_idx;
  logic [REG_AW-1:0] sel_rd;
  logic [XLEN-1:0]   sel_data;

  logic              wr_en_q;
  logic [REG_AW-1:0] rd_q;
  logic [XLEN-1:0]   data_q;
  logic [SW-1:0]     src_q;

  rr_arbiter #(.NUM_REQ(NUM_SRC)) u_rr (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_i         (src_valid_i),
    .hold_i        (hold_i),
    .grant_o       (src_ready_o),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  always_comb begin
    sel_rd   = src_rd_addr_i[int'(grant_idx)*REG_AW +: REG_AW];
    sel_data = src_data_i[int'(grant_idx)*XLEN +: XLEN];
  end

  // Writes to x0 are consumed but never enable the register file.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      src_q   <= '0;
    end else if (grant_valid) begin
      wr_en_q <= (sel_rd != '0);
      rd_q    <= sel_rd;
      data_q  <= sel_data;
      src_q   <= grant_idx;
    end else begin
      wr_en_q <= 1'b0;
    end
  end

  assign rf_wr_en_o   = wr_en_q;
  assign rf_rd_addr_o = rd_q;
  assign rf_wr_data_o = data_q;
  assign grant_src_o  = src_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: each scenario task drives vectors
// and compares ready/rf_* against hand-computed values.
module tb_wb_port_arbiter;

  logic         clk;
  logic         reset_n;
  logic [2:0]   src_valid;
  logic [14:0]  src_rd;
  logic [191:0] src_data;
  logic [2:0]   src_ready;
  logic         hold;
  logic         rf_wr_en;
  logic [4:0]   rf_rd_addr;
  logic [63:0]  rf_wr_data;
  logic [1:0]   grant_src;

  int checks;
  int failures;

  wb_port_arbiter #(.NUM_SRC(3), .XLEN(64), .REG_AW(5)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .src_valid_i   (src_valid),
    .src_rd_addr_i (src_rd),
    .src_data_i    (src_data),
    .src_ready_o   (src_ready),
    .hold_i        (hold),
    .rf_wr_en_o    (rf_wr_en),
    .rf_rd_addr_o  (rf_rd_addr),
    .rf_wr_data_o  (rf_wr_data),
    .grant_src_o   (grant_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [4:0] rd, input logic [63:0] d);
    src_valid[i]       = v;
    src_rd[i*5 +: 5]   = rd;
    src_data[i*64 +: 64] = d;
  endtask

  task automatic apply_reset();
    reset_n   = 1'b0;
    src_valid = '0;
    hold      = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    hold      = 1'b0;
    src_valid = 3'b111;
    src_rd    = '1;
    src_data  = '1;
    #2;
    checks++;
    if (src_ready !== 3'b000) begin
      failures++; $display("FAIL reset_ready got=%b exp=000", src_ready);
    end
    step();
    checks++;
    if (rf_wr_en !== 1'b0 || rf_rd_addr !== 5'd0 || rf_wr_data !== 64'd0 || grant_src !== 2'd0) begin
      failures++;
      $display("FAIL reset_outputs got en=%b rd=%0d data=%h src=%0d exp all zero",
               rf_wr_en, rf_rd_addr, rf_wr_data, grant_src);
    end
    src_valid = '0;
    reset_n   = 1'b1;
  endtask

  task automatic test_single();
    set_src(0, 1'b1, 5'd5, 64'hDEAD_BEEF);
    #1;
    checks++;
    if (src_ready !== 3'b001) begin
      failures++; $display("FAIL single_ready got=%b exp=001", src_ready);
    end
    step();
    set_src(0, 1'b0, 5'd0, 64'd0);
    checks++;
    if (rf_wr_en !== 1'b1 || rf_rd_addr !== 5'd5 || rf_wr_data !== 64'hDEAD_BEEF || grant_src !== 2'd0) begin
      failures++;
      $display("FAIL single_write got en=%b rd=%0d data=%h src=%0d exp en=1 rd=5 data=deadbeef src=0",
               rf_wr_en, rf_rd_addr, rf_wr_data, grant_src);
    end
    step();
    checks++;
    if (rf_wr_en !== 1'b0 || rf_rd_addr !== 5'd5) begin
      failures++; $display("FAIL single_idle got en=%b rd=%0d exp en=0 rd=5", rf_wr_en, rf_rd_addr);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_r;
    apply_reset();
    for (int i = 0; i < 3; i++) set_src(i, 1'b1, 5'(10 + i), 64'(32'hA000 + i));
    for (int c = 0; c < 6; c++) begin
      #1;
      exp_r = 3'b001 << (c % 3);
      checks++;
      if (src_ready !== exp_r) begin
        failures++; $display("FAIL rr_ready cycle=%0d got=%b exp=%b", c, src_ready, exp_r);
      end
      step();
      checks++;
      if (rf_rd_addr !== 5'(10 + c % 3) || grant_src !== 2'(c % 3) || rf_wr_en !== 1'b1) begin
        failures++;
        $display("FAIL rr_write cycle=%0d got rd=%0d src=%0d en=%b exp rd=%0d src=%0d en=1",
                 c, rf_rd_addr, grant_src, rf_wr_en, 10 + c % 3, c % 3);
      end
    end
    src_valid = '0;
  endtask

  task automatic test_x0();
    set_src(1, 1'b1, 5'd0, 64'h1234);
    #1;
    checks++;
    if (src_ready !== 3'b010) begin
      failures++; $display("FAIL x0_ready got=%b exp=010", src_ready);
    end
    step();
    checks++;
    if (rf_wr_en !== 1'b0 || rf_rd_addr !== 5'd0 || rf_wr_data !== 64'h1234 || grant_src !== 2'd1) begin
      failures++;
      $display("FAIL x0_write got en=%b rd=%0d data=%h src=%0d exp en=0 rd=0 data=1234 src=1",
               rf_wr_en, rf_rd_addr, rf_wr_data, grant_src);
    end
    set_src(0, 1'b1, 5'd20, 64'h20);
    set_src(1, 1'b1, 5'd21, 64'h21);
    set_src(2, 1'b1, 5'd22, 64'h22);
    #1;
    checks++;
    if (src_ready !== 3'b100) begin
      failures++; $display("FAIL x0_ptr_next got=%b exp=100", src_ready);
    end
    step();
    src_valid = '0;
    checks++;
    if (rf_wr_en !== 1'b1 || rf_rd_addr !== 5'd22 || grant_src !== 2'd2) begin
      failures++;
      $display("FAIL x0_followup got en=%b rd=%0d src=%0d exp en=1 rd=22 src=2", rf_wr_en, rf_rd_addr, grant_src);
    end
  endtask

  task automatic test_hold();
    hold = 1'b1;
    set_src(2, 1'b1, 5'd7, 64'h77);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (src_ready !== 3'b000) begin
        failures++; $display("FAIL hold_ready cycle=%0d got=%b exp=000", c, src_ready);
      end
      step();
      checks++;
      if (rf_wr_en !== 1'b0 || rf_rd_addr !== 5'd22) begin
        failures++; $display("FAIL hold_write cycle=%0d got en=%b rd=%0d exp en=0 rd=22", c, rf_wr_en, rf_rd_addr);
      end
    end
    hold = 1'b0;
    #1;
    checks++;
    if (src_ready !== 3'b100) begin
      failures++; $display("FAIL hold_release_ready got=%b exp=100", src_ready);
    end
    step();
    src_valid = '0;
    checks++;
    if (rf_wr_en !== 1'b1 || rf_rd_addr !== 5'd7 || rf_wr_data !== 64'h77) begin
      failures++; $display("FAIL hold_release_write got en=%b rd=%0d data=%h exp en=1 rd=7 data=77",
                           rf_wr_en, rf_rd_addr, rf_wr_data);
    end
  endtask

  task automatic test_reset_mid_write();
    apply_reset();
    step();
    set_src(1, 1'b1, 5'd9, 64'h99);
    #1;
    checks++;
    if (src_ready !== 3'b010) begin
      failures++; $display("FAIL mid_ready got=%b exp=010", src_ready);
    end
    #2;
    reset_n = 1'b0;
    set_src(0, 1'b1, 5'd4, 64'h44);
    #1;
    checks++;
    if (rf_wr_en !== 1'b0 || src_ready !== 3'b000) begin
      failures++; $display("FAIL mid_reset got en=%b ready=%b exp en=0 ready=000", rf_wr_en, src_ready);
    end
    step();
    checks++;
    if (rf_wr_en !== 1'b0 || rf_rd_addr !== 5'd0) begin
      failures++; $display("FAIL mid_dropped got en=%b rd=%0d exp en=0 rd=0", rf_wr_en, rf_rd_addr);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (src_ready !== 3'b001) begin
      failures++; $display("FAIL mid_regrant0 got=%b exp=001", src_ready);
    end
    step();
    set_src(0, 1'b0, 5'd0, 64'd0);
    #1;
    checks++;
    if (rf_wr_en !== 1'b1 || rf_rd_addr !== 5'd4 || src_ready !== 3'b010) begin
      failures++; $display("FAIL mid_regrant1 got en=%b rd=%0d ready=%b exp en=1 rd=4 ready=010",
                           rf_wr_en, rf_rd_addr, src_ready);
    end
    step();
    src_valid = '0;
    checks++;
    if (rf_wr_en !== 1'b1 || rf_rd_addr !== 5'd9 || rf_wr_data !== 64'h99 || grant_src !== 2'd1) begin
      failures++; $display("FAIL mid_src1_write got en=%b rd=%0d data=%h src=%0d exp en=1 rd=9 data=99 src=1",
                           rf_wr_en, rf_rd_addr, rf_wr_data, grant_src);
    end
  endtask

  task automatic test_withdraw();
    apply_reset();
    set_src(0, 1'b1, 5'd1, 64'h1);
    step();
    set_src(0, 1'b1, 5'd2, 64'h2);
    set_src(1, 1'b1, 5'd3, 64'h3);
    #1;
    checks++;
    if (src_ready !== 3'b010) begin
      failures++; $display("FAIL wd_ready got=%b exp=010", src_ready);
    end
    step();
    src_valid = '0;
    #1;
    checks++;
    if (rf_wr_en !== 1'b1 || rf_rd_addr !== 5'd3 || src_ready !== 3'b000) begin
      failures++; $display("FAIL wd_write got en=%b rd=%0d ready=%b exp en=1 rd=3 ready=000",
                           rf_wr_en, rf_rd_addr, src_ready);
    end
    step();
    checks++;
    if (rf_wr_en !== 1'b0 || rf_rd_addr !== 5'd3 || grant_src !== 2'd1) begin
      failures++; $display("FAIL wd_idle got en=%b rd=%0d src=%0d exp en=0 rd=3 src=1", rf_wr_en, rf_rd_addr, grant_src);
    end
    src_valid = 3'b111;
    #1;
    checks++;
    if (src_ready !== 3'b100) begin
      failures++; $display("FAIL wd_ptr got=%b exp=100", src_ready);
    end
    step();
    src_valid = '0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    src_valid = '0;
    src_rd    = '0;
    src_data  = '0;
    hold      = 1'b0;
    reset_n   = 1'b0;
    #3;
    test_reset();
    test_single();
    test_round_robin();
    test_x0();
    test_hold();
    test_reset_mid_write();
    test_withdraw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
